// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot-time loader and port controller for the single-cycle core's
// instruction memory. After reset the core is held stalled. A start
// request with a legal length opens a valid/ready stream. Each accepted
// word is written to consecutive word addresses starting at byte 0.
// When loading is complete, the memory address port is handed to the
// core's PC.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - one-cycle load request; load_len is sampled with it
//   load_len     - number of words to load (1..DEPTH)
//   s_valid      - stream handshake input
//   s_data       - stream word input
//   s_ready      - stream handshake output
//   cpu_pc       - fetch byte address from the PC register
//   cpu_stall    - holds the PC while the program is not yet runnable
//   mem_we       - instruction memory write enable
//   mem_addr     - instruction memory byte address
//   mem_wdata    - instruction memory write data
//   busy         - loader is in LOAD or FLUSH
//   done         - one-cycle pulse on entry to RUN
//   error        - sticky flag; the last start was rejected
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32,
  parameter int DEPTH      = 128,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic [ADD_WIDTH-1:0]  cpu_pc,
  output logic                  cpu_stall,
  output logic                  mem_we,
  output logic [ADD_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count;
  logic [ADD_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  we_q;
  logic                  done_q;
  logic                  error_q;

  logic                  hs;
  logic                  can_start;
  logic                  start_ok;
  logic                  start_bad;
  logic                  last_hs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Starts are honoured only in IDLE or RUN. A rejected
  // start leaves the state as it is, so a running core keeps running.
  always_comb begin
    hs         = (state == LOAD) && s_valid;
    can_start  = start && ((state == IDLE) || (state == RUN));
    start_ok   = can_start && (load_len != '0) && (load_len <= DEPTH_L);
    start_bad  = can_start && !start_ok;
    last_hs    = hs && (count == (len_q - ONE_L));
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    if (last_hs)  state_next = FLUSH;
      FLUSH:   state_next = RUN;
      RUN:     if (start_ok) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Each handshake is registered so the write reaches the
  // memory one cycle later. This is why a FLUSH cycle exists: it carries
  // the final write. done is registered from FLUSH because RUN is only
  // ever entered from FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      count   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      we_q   <= hs;
      done_q <= (state == FLUSH);
      if (start_ok) begin
        len_q   <= load_len;
        count   <= '0;
        error_q <= 1'b0;
      end else if (start_bad) begin
        error_q <= 1'b1;
      end
      if (hs) begin
        wr_addr <= ADD_WIDTH'(count) << 2;
        wr_data <= s_data;
        count   <= count + ONE_L;
      end
    end
  end

  assign s_ready   = (state == LOAD);
  assign cpu_stall = (state != RUN);
  assign busy      = (state == LOAD) || (state == FLUSH);
  assign mem_we    = we_q;
  assign mem_addr  = (state == RUN) ? cpu_pc : wr_addr;
  assign mem_wdata = wr_data;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader. Stimulus tasks push the expected memory
// writes and done pulses into queues. A negedge monitor pops them whenever
// the DUT presents mem_we or done.
module tb_imem_boot_loader;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] load_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] cpu_pc;
  logic          cpu_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  checks  = 0;
  int  errors  = 0;
  int  exp_idx = 0;
  int  cur_len = 0;

  imem_boot_loader #(
    .DATA_WIDTH(DW), .ADD_WIDTH(AW), .DEPTH(128), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    checkOutput("rst_s_ready",   32'(s_ready),   32'd0);
    checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
    checkOutput("rst_mem_addr",  mem_addr,       32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,      32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_error",     32'(error),     32'd0);
  endtask

  // Issue a start; a legal one resets the expected-address counter.
  task automatic startLoad(input int len, input bit legal);
    start    = 1'b1;
    load_len = LW'(len);
    if (legal) begin
      cur_len = len;
      exp_idx = 0;
    end
    tick();
    start = 1'b0;
  endtask

  // Drive one stream cycle. An offered word in LOAD is accepted, so its
  // write (and the done pulse for the last word) is expected.
  task automatic applyStimulus(input logic [31:0] d, input bit v,
                               input bit expect_wr);
    s_valid = v;
    s_data  = d;
    if (v) begin
      if (expect_wr) exp_wr.push_back('{addr: 32'(exp_idx * 4), data: d});
      if (exp_idx == cur_len - 1) exp_done.push_back(1);
      exp_idx++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          checkOutput("wr_addr", mem_addr,  e.addr);
          checkOutput("wr_data", mem_wdata, e.data);
        end
      end
      if (done === 1'b1) begin
        checkOutput("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) void'(exp_done.pop_front());
        checkOutput("done_stall", 32'(cpu_stall), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  logic [31:0] gap_words [4];

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    load_len = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    cpu_pc   = 32'h1234;
    #1;
    checkReset();
    tick();
    tick();
    rst_n = 1'b1;

    // Idle: offered words are never accepted
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hBAD0_0000 + 32'(i);
      tick();
      checkOutput("idle_s_ready",   32'(s_ready),   32'd0);
      checkOutput("idle_mem_we",    32'(mem_we),    32'd0);
      checkOutput("idle_cpu_stall", 32'(cpu_stall), 32'd1);
      checkOutput("idle_mem_addr",  mem_addr,       32'd0);
    end
    s_valid = 1'b0;

    // Zero-length start in IDLE is rejected
    startLoad(0, 1'b0);
    checkOutput("len0_error", 32'(error),   32'd1);
    checkOutput("len0_busy",  32'(busy),    32'd0);
    checkOutput("len0_ready", 32'(s_ready), 32'd0);
    tick();
    checkOutput("len0_still_idle", 32'(busy), 32'd0);

    // Three back-to-back words
    startLoad(3, 1'b1);
    checkOutput("l3_ready", 32'(s_ready),   32'd1);
    checkOutput("l3_stall", 32'(cpu_stall), 32'd1);
    checkOutput("l3_busy",  32'(busy),      32'd1);
    checkOutput("l3_error", 32'(error),     32'd0);
    applyStimulus(32'h2008_0005, 1'b1, 1'b1);
    applyStimulus(32'h2009_0003, 1'b1, 1'b1);
    applyStimulus(32'h0109_5020, 1'b1, 1'b1);
    checkOutput("l3_flush_ready", 32'(s_ready),   32'd0);
    checkOutput("l3_flush_busy",  32'(busy),      32'd1);
    checkOutput("l3_flush_stall", 32'(cpu_stall), 32'd1);
    checkOutput("l3_flush_we",    32'(mem_we),    32'd1);
    checkOutput("l3_flush_addr",  mem_addr,       32'h8);
    tick();
    checkOutput("l3_done",  32'(done),      32'd1);
    checkOutput("l3_stall_run", 32'(cpu_stall), 32'd0);
    checkOutput("l3_busy_run",  32'(busy),      32'd0);
    tick();
    checkOutput("l3_done_pulse", 32'(done), 32'd0);
    cpu_pc = 32'h0;  #1; checkOutput("pc_0",  mem_addr, 32'h0);
    cpu_pc = 32'h4;  #1; checkOutput("pc_4",  mem_addr, 32'h4);
    cpu_pc = 32'h10; #1; checkOutput("pc_10", mem_addr, 32'h10);

    // Reload from RUN with s_valid gaps; a start mid-load is ignored
    gap_words[0] = 32'h1111_0001;
    gap_words[1] = 32'h2222_0002;
    gap_words[2] = 32'h3333_0003;
    gap_words[3] = 32'h4444_0004;
    tick();
    startLoad(4, 1'b1);
    checkOutput("l4_stall", 32'(cpu_stall), 32'd1);
    applyStimulus(gap_words[0], 1'b1, 1'b1);
    start    = 1'b1;
    load_len = '0;
    tick();
    start = 1'b0;
    checkOutput("l4_ignored_start_error", 32'(error), 32'd0);
    checkOutput("l4_ignored_start_busy",  32'(busy),  32'd1);
    applyStimulus(gap_words[1], 1'b1, 1'b1);
    applyStimulus(gap_words[2], 1'b1, 1'b1);
    applyStimulus(32'hDEAD_0000, 1'b0, 1'b0);
    applyStimulus(gap_words[3], 1'b1, 1'b1);
    checkOutput("l4_flush_addr", mem_addr, 32'hC);
    tick();
    checkOutput("l4_done", 32'(done), 32'd1);
    tick();

    // Oversized start in RUN: rejected, the core keeps running
    cpu_pc = 32'h20;
    startLoad(129, 1'b0);
    checkOutput("len129_error", 32'(error),     32'd1);
    checkOutput("len129_stall", 32'(cpu_stall), 32'd0);
    checkOutput("len129_busy",  32'(busy),      32'd0);
    checkOutput("len129_addr",  mem_addr,       32'h20);

    // Legal start of one word clears error
    startLoad(1, 1'b1);
    checkOutput("len1_error", 32'(error), 32'd0);
    checkOutput("len1_busy",  32'(busy),  32'd1);
    applyStimulus(32'h0000_00AA, 1'b1, 1'b1);
    tick();
    checkOutput("len1_done", 32'(done), 32'd1);
    tick();

    // Full depth; the extra word is refused
    startLoad(128, 1'b1);
    for (int i = 0; i < 128; i++) applyStimulus(32'hA500_0000 + 32'(i), 1'b1, 1'b1);
    checkOutput("full_last_addr", mem_addr, 32'h1FC);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    #1;
    checkOutput("full_extra_ready_flush", 32'(s_ready), 32'd0);
    tick();
    checkOutput("full_extra_ready_run", 32'(s_ready), 32'd0);
    checkOutput("full_done",            32'(done),    32'd1);
    tick();
    s_valid = 1'b0;
    tick();

    // Reset mid-load after two of five words
    startLoad(5, 1'b1);
    applyStimulus(32'h5555_0000, 1'b1, 1'b1);
    applyStimulus(32'h5555_0001, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkReset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h6666_0000 + 32'(i);
      tick();
      checkOutput("post_rst_ready", 32'(s_ready),   32'd0);
      checkOutput("post_rst_busy",  32'(busy),      32'd0);
      checkOutput("post_rst_stall", 32'(cpu_stall), 32'd1);
    end
    s_valid = 1'b0;
    tick();
    tick();

    checkOutput("pending_writes", 32'(exp_wr.size()),   32'd0);
    checkOutput("pending_done",   32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
